// File: rtl/ribbon_pkg.sv
// Shared types and helpers for the ribbon note tracker.
package ribbon_pkg;

   localparam int unsigned NUM_ZONES = 12;

   typedef logic [3:0] zone_t;
   typedef logic [6:0] note_t;

   typedef enum logic [1:0] {IDLE, SEND_OFF, SEND_ON} tracker_state_t;

   // Out-of-range decoder codes mean "no touch".
   function automatic zone_t zone_clamp(input logic [7:0] raw);
      if (raw > 8'(NUM_ZONES)) begin
         return '0;
      end
      return raw[3:0];
   endfunction

endpackage

// File: rtl/ribbon_debounce.sv
// Periodic zone sampler with consecutive-sample debounce.
// stable_o is high while the candidate has been seen STABLE_N samples in a row.
module ribbon_debounce
   import ribbon_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = 100000,
   parameter int unsigned STABLE_N   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] zone_i,
   output zone_t      stable_zone_o,
   output logic       stable_o
);

   localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned StW  = $clog2(STABLE_N + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   zone_t           cand_q, cand_d;
   logic [StW-1:0]  stab_q, stab_d;
   logic            tick;
   zone_t           sample;

   assign tick   = (cnt_q == CntW'(SAMPLE_DIV - 1));
   assign sample = zone_clamp(zone_i);

   // Sample counter and debounce next-state.
   always_comb begin
      cnt_d  = tick ? '0 : cnt_q + 1'b1;
      cand_d = cand_q;
      stab_d = stab_q;
      if (tick) begin
         if (sample == cand_q) begin
            if (stab_q != StW'(STABLE_N)) begin
               stab_d = stab_q + 1'b1;
            end
         end else begin
            cand_d = sample;
            stab_d = StW'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         cand_q <= '0;
         stab_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         cand_q <= cand_d;
         stab_q <= stab_d;
      end
   end

   assign stable_zone_o = cand_q;
   assign stable_o      = (stab_q == StW'(STABLE_N));

endmodule

// File: rtl/ribbon_note_tracker.sv
// Ribbon note tracker: debounced zone commits become note-on/off events on a
// valid/ready stream. Define RIBBON_LEGATO_EN to turn zone slides into a single
// note-on (no intervening note-off).
module ribbon_note_tracker
   import ribbon_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = 100000,
   parameter int unsigned STABLE_N   = 4,
   parameter int unsigned BASE_NOTE  = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] zone_in,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic       evt_on,
   output logic [6:0] evt_note,
   output logic [3:0] active_zone,
   output logic       touching
);

   if (BASE_NOTE + NUM_ZONES - 1 > 127) begin : g_bad_base_note
      $error("BASE_NOTE + 11 must not exceed 127");
   end
   if (SAMPLE_DIV < 2) begin : g_bad_sample_div
      $error("SAMPLE_DIV must be at least 2");
   end

   function automatic note_t to_note(input zone_t z);
      return note_t'(BASE_NOTE + 32'(z) - 1);
   endfunction

   zone_t          stable_zone;
   logic           stable;
   logic           commit;

   tracker_state_t state_q, state_d;
   zone_t          active_q, active_d;
   logic           on_q, on_d;
   note_t          note_q, note_d;
   logic           pend_q, pend_d;          // note-on queued behind a note-off
   note_t          pend_note_q, pend_note_d;

   ribbon_debounce #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .STABLE_N   (STABLE_N)
   ) u_debounce (
      .clk           (clk),
      .rst_n         (rst_n),
      .zone_i        (zone_in),
      .stable_zone_o (stable_zone),
      .stable_o      (stable)
   );

   assign commit = stable && (stable_zone != active_q) && (state_q == IDLE);

   // Event FSM next-state and payload capture.
   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      on_d        = on_q;
      note_d      = note_q;
      pend_d      = pend_q;
      pend_note_d = pend_note_q;
      case (state_q)
         IDLE: begin
            if (commit) begin
               active_d = stable_zone;
               if (active_q == '0) begin
                  state_d = SEND_ON;
                  on_d    = 1'b1;
                  note_d  = to_note(stable_zone);
               end else if (stable_zone == '0) begin
                  state_d = SEND_OFF;
                  on_d    = 1'b0;
                  note_d  = to_note(active_q);
               end else begin
`ifdef RIBBON_LEGATO_EN
                  state_d = SEND_ON;
                  on_d    = 1'b1;
                  note_d  = to_note(stable_zone);
`else
                  state_d     = SEND_OFF;
                  on_d        = 1'b0;
                  note_d      = to_note(active_q);
                  pend_d      = 1'b1;
                  pend_note_d = to_note(stable_zone);
`endif
               end
            end
         end
         SEND_OFF: begin
            if (evt_ready) begin
               if (pend_q) begin
                  state_d = SEND_ON;
                  on_d    = 1'b1;
                  note_d  = pend_note_q;
                  pend_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         SEND_ON: begin
            if (evt_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and event payload registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         active_q    <= '0;
         on_q        <= 1'b0;
         note_q      <= '0;
         pend_q      <= 1'b0;
         pend_note_q <= '0;
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         on_q        <= on_d;
         note_q      <= note_d;
         pend_q      <= pend_d;
         pend_note_q <= pend_note_d;
      end
   end

   assign evt_valid   = (state_q != IDLE);
   assign evt_on      = on_q;
   assign evt_note    = note_q;
   assign active_zone = active_q;
   assign touching    = (active_q != '0);

endmodule
